// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and bus constants.
package spi_pkg;

  localparam int SPI_BITS    = 8;
  localparam int CLK_DIV_MIN = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    HOLD,
    GAP,
    WAIT
  } spi_master_state_t;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for a single asynchronous input, cleared by synchronous reset.
module spi_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_master_interface.sv
// Byte-wide mode-0 SPI master, MSB first, with optional burst (SS held low between bytes).
module spi_master_interface
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       last,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = $clog2(SPI_BITS);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(SPI_BITS - 1);

  // Slower dividers are fine; faster ones outrun the slaves' input synchronisers.
  if (CLK_DIV < CLK_DIV_MIN) begin : g_clk_div_check
    $error("spi_master_interface: CLK_DIV=%0d below minimum %0d", CLK_DIV, CLK_DIV_MIN);
  end

  spi_master_state_t state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              last_q, last_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_q, ss_d;
  logic              done_q, done_d;
  logic              miso_s;
  logic              div_zero;
  logic              ready_int;

  spi_sync2 u_miso_sync (
    .clk   (clk),
    .reset (reset),
    .d     (miso),
    .q     (miso_s)
  );

  assign div_zero  = (div_q == '0);
  assign ready_int = (state_q == IDLE) || (state_q == WAIT);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        ss_d   = 1'b1;
        if (start) begin
          tx_sh_d   = tx_data;
          last_d    = last;
          mosi_d    = tx_data[7];
          bit_cnt_d = '0;
          ss_d      = 1'b0;
          state_d   = SETUP;
        end
      end
      WAIT: begin
        sclk_d = 1'b0;
        ss_d   = 1'b0;
        if (start) begin
          tx_sh_d   = tx_data;
          last_d    = last;
          mosi_d    = tx_data[7];
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP, SCLK_LO: begin
        if (div_zero) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso_s};
          state_d = SCLK_HI;
        end
      end
      SCLK_HI: begin
        if (div_zero) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
            state_d   = HOLD;
          end else begin
            // Rotate rather than shift so every bit of the register stays live.
            tx_sh_d   = {tx_sh_q[6:0], tx_sh_q[7]};
            mosi_d    = tx_sh_q[6];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = SCLK_LO;
          end
        end
      end
      HOLD: begin
        if (div_zero) begin
          if (last_q) begin
            ss_d    = 1'b1;
            state_d = GAP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      GAP: begin
        if (div_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every timed state starts with a fresh CLK_DIV-cycle count.
    if ((state_d != state_q) || ready_int) begin
      div_d = DIV_RELOAD;
    end else begin
      div_d = div_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_data_q <= 8'h00;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_int;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss      = ss_q;

endmodule

// File: tb/tb_spi_master_interface.sv
// Directed bench for spi_master_interface: two instances (CLK_DIV=4 and 7) each with a mode-0 slave model.
module tb_spi_master_interface;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset   = 1'b1;
  logic [1:0]      start_r = '0;
  logic [1:0]      last_r  = '0;
  logic [1:0]      miso_r  = '0;
  logic [1:0][7:0] tx_r    = '0;
  logic [1:0]      ready_w, done_w, sclk_w, mosi_w, ss_w;
  logic [1:0][7:0] rx_w;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  spi_master_interface #(.CLK_DIV(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_r[0]), .last(last_r[0]), .tx_data(tx_r[0]),
    .ready(ready_w[0]), .done(done_w[0]), .rx_data(rx_w[0]), .sclk(sclk_w[0]),
    .mosi(mosi_w[0]), .miso(miso_r[0]), .ss(ss_w[0])
  );

  spi_master_interface #(.CLK_DIV(7)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_r[1]), .last(last_r[1]), .tx_data(tx_r[1]),
    .ready(ready_w[1]), .done(done_w[1]), .rx_data(rx_w[1]), .sclk(sclk_w[1]),
    .mosi(mosi_w[1]), .miso(miso_r[1]), .ss(ss_w[1])
  );

  function automatic int cdv(input int i);
    return (i == 0) ? 4 : 7;
  endfunction

  // Written by the stimulus process only
  int         base[2]     = '{0, 0};
  int         epoch[2]    = '{0, 0};
  logic [7:0] slv_byte[2] = '{8'h00, 8'h00};
  int         dly[2]      = '{0, 0};

  // Written by the monitor / slave model only
  int         seen[2]        = '{0, 0};
  int         rise_cnt[2]    = '{0, 0};
  int         rise_at[2][32];
  int         last_rise[2]   = '{0, 0};
  int         gap_bad[2]     = '{0, 0};
  int         done_cnt[2]    = '{0, 0};
  int         done_at[2][8];
  logic [7:0] done_dat[2][8];
  int         ss_rise_rel[2] = '{-1, -1};
  int         ss_fall[2]     = '{0, 0};
  int         ready_rel[2]   = '{-1, -1};
  logic [7:0] slv_last[2]    = '{8'h00, 8'h00};
  logic [7:0] slv_prev[2]    = '{8'h00, 8'h00};
  logic [7:0] stx[2]         = '{8'h00, 8'h00};
  logic [7:0] srx[2]         = '{8'h00, 8'h00};
  int         bitc[2]        = '{0, 0};
  int         rbit[2]        = '{0, 0};
  logic       pend_act[2]    = '{1'b0, 1'b0};
  int         pend_cnt[2]    = '{0, 0};
  logic       pend_val[2]    = '{1'b0, 1'b0};
  logic       prev_sclk[2]   = '{1'b0, 1'b0};
  logic       prev_ss[2]     = '{1'b1, 1'b1};
  logic       prev_ready[2]  = '{1'b1, 1'b1};
  int         mon_rel;

  // Mode-0 slave: drives MISO after each falling edge (optionally delayed), samples MOSI on rising edges
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (seen[i] != epoch[i]) begin
        seen[i]        = epoch[i];
        rise_cnt[i]    = 0;
        last_rise[i]   = 0;
        gap_bad[i]     = 0;
        done_cnt[i]    = 0;
        ss_rise_rel[i] = -1;
        ss_fall[i]     = 0;
        ready_rel[i]   = -1;
      end
      mon_rel = cyc - base[i];
      if (pend_act[i]) begin
        if (pend_cnt[i] == 0) begin
          miso_r[i]   = pend_val[i];
          pend_act[i] = 1'b0;
        end else begin
          pend_cnt[i] = pend_cnt[i] - 1;
        end
      end
      if (!ss_w[i] && prev_ss[i]) begin
        stx[i]      = slv_byte[i];
        miso_r[i]   = slv_byte[i][7];
        bitc[i]     = 0;
        rbit[i]     = 0;
        pend_act[i] = 1'b0;
        ss_fall[i]  = ss_fall[i] + 1;
      end
      if (ss_w[i] && !prev_ss[i]) begin
        if (ss_rise_rel[i] < 0) ss_rise_rel[i] = mon_rel;
        bitc[i] = 0;
        rbit[i] = 0;
      end
      if (sclk_w[i] && !prev_sclk[i]) begin
        if (rise_cnt[i] < 32) rise_at[i][rise_cnt[i]] = mon_rel;
        if ((rise_cnt[i] % 8) != 0 && (mon_rel - last_rise[i]) != 2 * cdv(i))
          gap_bad[i] = gap_bad[i] + 1;
        last_rise[i] = mon_rel;
        rise_cnt[i]  = rise_cnt[i] + 1;
        if (!ss_w[i]) begin
          srx[i]  = {srx[i][6:0], mosi_w[i]};
          rbit[i] = rbit[i] + 1;
          if (rbit[i] == 8) begin
            slv_prev[i] = slv_last[i];
            slv_last[i] = srx[i];
            rbit[i]     = 0;
          end
        end
      end
      if (!sclk_w[i] && prev_sclk[i] && !ss_w[i]) begin
        bitc[i] = bitc[i] + 1;
        if (bitc[i] == 8) begin
          bitc[i] = 0;
          stx[i]  = slv_byte[i];
        end else begin
          stx[i] = {stx[i][6:0], 1'b0};
        end
        pend_val[i] = stx[i][7];
        pend_cnt[i] = dly[i];
        pend_act[i] = 1'b1;
      end
      if (done_w[i]) begin
        if (done_cnt[i] < 8) begin
          done_at[i][done_cnt[i]]  = mon_rel;
          done_dat[i][done_cnt[i]] = rx_w[i];
        end
        done_cnt[i] = done_cnt[i] + 1;
      end
      if (ready_w[i] && !prev_ready[i] && ready_rel[i] < 0) ready_rel[i] = mon_rel;
      prev_sclk[i]  = sclk_w[i];
      prev_ss[i]    = ss_w[i];
      prev_ready[i] = ready_w[i];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic clr(input int i);
    base[i]  = cyc;
    epoch[i] = epoch[i] + 1;
  endtask

  task automatic wait_ready(input int i, input int lim, input string nm);
    int n = 0;
    while (!ready_w[i] && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!ready_w[i]) timeout(nm);
  endtask

  task automatic wait_idle(input int i, input int lim, input string nm);
    int n = 0;
    while (!(ready_w[i] && ss_w[i]) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!(ready_w[i] && ss_w[i])) timeout(nm);
  endtask

  // Present one byte for exactly one cycle, then scramble the don't-care inputs
  task automatic xfer(input int i, input logic [7:0] d, input logic l);
    start_r[i] = 1'b1;
    tx_r[i]    = d;
    last_r[i]  = l;
    @(negedge clk);
    start_r[i] = 1'b0;
    tx_r[i]    = ~d;
    last_r[i]  = ~l;
  endtask

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] slv;
    int         dl;
    int         exp_rise0;
    int         exp_done;
    int         exp_ss;
    int         exp_rdy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 8'hA5, 8'h3C, 0, 5, 65, 69, 73};
    vecs[1] = '{0, 8'h00, 8'hFF, 0, 5, 65, 69, 73};
    vecs[2] = '{0, 8'hFF, 8'h00, 0, 5, 65, 69, 73};
    vecs[3] = '{0, 8'h5A, 8'h81, 0, 5, 65, 69, 73};
    vecs[4] = '{1, 8'h80, 8'hFF, 0, 8, 113, 120, 127};
    vecs[5] = '{1, 8'h69, 8'h96, 2, 8, 113, 120, 127};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_ready", i), ready_w[i], 1);
      chk($sformatf("rst%0d_ss", i), ss_w[i], 1);
      chk($sformatf("rst%0d_sclk", i), sclk_w[i], 0);
      chk($sformatf("rst%0d_mosi", i), mosi_w[i], 0);
      chk($sformatf("rst%0d_done", i), done_w[i], 0);
      chk($sformatf("rst%0d_rx", i), rx_w[i], 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      int i;
      i = vecs[k].inst;
      slv_byte[i] = vecs[k].slv;
      dly[i]      = vecs[k].dl;
      wait_idle(i, 500, $sformatf("v%0d_pre", k));
      clr(i);
      xfer(i, vecs[k].tx, 1'b1);
      wait_idle(i, 500, $sformatf("v%0d_post", k));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_slave_rx", k), slv_last[i], vecs[k].tx);
      chk($sformatf("v%0d_done_cnt", k), done_cnt[i], 1);
      chk($sformatf("v%0d_rx_at_done", k), done_dat[i][0], vecs[k].slv);
      chk($sformatf("v%0d_rx_held", k), rx_w[i], vecs[k].slv);
      chk($sformatf("v%0d_done_cyc", k), done_at[i][0], vecs[k].exp_done);
      chk($sformatf("v%0d_ss_rise_cyc", k), ss_rise_rel[i], vecs[k].exp_ss);
      chk($sformatf("v%0d_ready_cyc", k), ready_rel[i], vecs[k].exp_rdy);
      chk($sformatf("v%0d_rises", k), rise_cnt[i], 8);
      chk($sformatf("v%0d_first_rise", k), rise_at[i][0], vecs[k].exp_rise0);
      chk($sformatf("v%0d_rise_spacing", k), rise_at[i][1] - rise_at[i][0], 2 * cdv(i));
      chk($sformatf("v%0d_gap_bad", k), gap_bad[i], 0);
    end

    // Burst: second byte accepted the cycle ready rises in WAIT
    slv_byte[0] = 8'h6B;
    dly[0]      = 0;
    clr(0);
    xfer(0, 8'h01, 1'b0);
    wait_ready(0, 200, "burst_wait");
    chk("burst_ready_cyc", cyc - base[0], 69);
    chk("burst_ss_low_in_wait", ss_w[0], 0);
    xfer(0, 8'hFF, 1'b1);
    wait_idle(0, 500, "burst_end");
    repeat (2) @(negedge clk);
    chk("burst_ss_fall_cnt", ss_fall[0], 1);
    chk("burst_ss_rise_cyc", ss_rise_rel[0], 138);
    chk("burst_rises", rise_cnt[0], 16);
    chk("burst_done_cnt", done_cnt[0], 2);
    chk("burst_done0_cyc", done_at[0][0], 65);
    chk("burst_done1_cyc", done_at[0][1], 134);
    chk("burst_rx0", done_dat[0][0], 8'h6B);
    chk("burst_rx1", done_dat[0][1], 8'h6B);
    chk("burst_slave_byte0", slv_prev[0], 8'h01);
    chk("burst_slave_byte1", slv_last[0], 8'hFF);
    chk("burst_second_first_rise", rise_at[0][8], 74);
    chk("burst_gap_bad", gap_bad[0], 0);

    // start held high: one transfer per ready window
    slv_byte[0] = 8'h3C;
    clr(0);
    start_r[0] = 1'b1;
    tx_r[0]    = 8'h55;
    last_r[0]  = 1'b1;
    repeat (200) @(negedge clk);
    start_r[0] = 1'b0;
    wait_idle(0, 500, "held_end");
    repeat (2) @(negedge clk);
    chk("held_ss_falls", ss_fall[0], 3);
    chk("held_rises", rise_cnt[0], 24);
    chk("held_done_cnt", done_cnt[0], 3);
    chk("held_done1_cyc", done_at[0][1], 138);
    chk("held_done2_cyc", done_at[0][2], 211);
    chk("held_gap_bad", gap_bad[0], 0);
    chk("held_slave_rx", slv_last[0], 8'h55);
    chk("held_rx", done_dat[0][2], 8'h3C);

    // Reset during SCLK_HI of bit 3
    slv_byte[0] = 8'hA5;
    clr(0);
    xfer(0, 8'h5A, 1'b1);
    repeat (29) @(negedge clk);
    chk("rstmid_pre_sclk", sclk_w[0], 1);
    chk("rstmid_pre_mosi", mosi_w[0], 1);
    chk("rstmid_pre_rises", rise_cnt[0], 4);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_sclk", sclk_w[0], 0);
    chk("rstmid_ss", ss_w[0], 1);
    chk("rstmid_mosi", mosi_w[0], 0);
    chk("rstmid_ready", ready_w[0], 1);
    chk("rstmid_done", done_w[0], 0);
    chk("rstmid_rx", rx_w[0], 0);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    chk("rstmid_no_done", done_cnt[0], 0);

    slv_byte[0] = 8'h5E;
    clr(0);
    xfer(0, 8'hC3, 1'b1);
    wait_idle(0, 500, "after_rst_end");
    repeat (2) @(negedge clk);
    chk("after_rst_slave_rx", slv_last[0], 8'hC3);
    chk("after_rst_rx", done_dat[0][0], 8'h5E);
    chk("after_rst_done_cyc", done_at[0][0], 65);
    chk("after_rst_rises", rise_cnt[0], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
